frame_sequencer: RTL and testbench

Frame-level controller in front of the image filter path (convolutor + output pixel memory). It arms on a start pulse and forwards exactly row_depth*column_depth UART-RX bytes into the filter's pixel input. It then waits for the pipeline to flush and paces readout of the filtered pixels through the filter's read-request handshake into the UART TX, one byte per TX-idle window. It reports busy, frame-done and sticky error status to the top level.

---
 rtl/frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame controller: arms on i_start, forwards one frame of RX bytes to the filter, then paces filtered readout into UART TX.
// Latency: RX->conv 1 cycle, filter response->TX 1 cycle; readout stalls while TX is busy and each request may time out.
module frame_sequencer #(
  parameter int row_depth    = 450,
  parameter int column_depth = 500,
  parameter int D_BITS       = 8,
  parameter int OUT_PIXELS   = (row_depth - 2) * (column_depth - 2),
  parameter int DRAIN_CYC    = 4,
  parameter int RD_TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [D_BITS-1:0] i_rx_data,
  output logic              o_conv_drdy,
  output logic [D_BITS-1:0] o_conv_data,
  output logic              o_filt_rd,
  input  logic              i_filt_valid,
  input  logic [D_BITS-1:0] i_filt_data,
  input  logic              i_tx_idle,
  output logic              o_tx_start,
  output logic [D_BITS-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_overrun,
  output logic              o_err_timeout
);

  localparam int IN_PIXELS = row_depth * column_depth;
  localparam int IN_W      = $clog2(IN_PIXELS);
  localparam int OUT_W     = $clog2(OUT_PIXELS + 1);
  localparam int DR_W      = $clog2(DRAIN_CYC + 1);
  localparam int TO_W      = $clog2(RD_TIMEOUT + 1);

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_PIXELS - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_PIXELS - 1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [DR_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               outstanding_q, outstanding_d;
  logic               conv_drdy_q, conv_drdy_d;
  logic [D_BITS-1:0]  conv_data_q, conv_data_d;
  logic               filt_rd_q, filt_rd_d;
  logic               tx_start_q, tx_start_d;
  logic [D_BITS-1:0]  tx_data_q, tx_data_d;
  logic               frame_done_q, frame_done_d;
  logic               err_ovr_q, err_ovr_d;
  logic               err_to_q, err_to_d;
  logic               req_ok;
  logic               issue;

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      to_cnt_q      <= '0;
      outstanding_q <= 1'b0;
      conv_drdy_q   <= 1'b0;
      conv_data_q   <= '0;
      filt_rd_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_done_q  <= 1'b0;
      err_ovr_q     <= 1'b0;
      err_to_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      to_cnt_q      <= to_cnt_d;
      outstanding_q <= outstanding_d;
      conv_drdy_q   <= conv_drdy_d;
      conv_data_q   <= conv_data_d;
      filt_rd_q     <= filt_rd_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      frame_done_q  <= frame_done_d;
      err_ovr_q     <= err_ovr_d;
      err_to_q      <= err_to_d;
    end
  end

  // A tx_start pulse on the output means the last launch was one cycle ago, so the next
  // request must wait one more cycle to keep two cycles between launch and request.
  assign req_ok = i_tx_idle && !outstanding_q && !tx_start_q;
  assign issue  = req_ok && ((state_q == S_SEND) ||
                             (state_q == S_DRAIN && drain_cnt_q == DR_LAST));

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    to_cnt_d      = to_cnt_q;
    outstanding_d = outstanding_q;
    conv_drdy_d   = 1'b0;
    conv_data_d   = conv_data_q;
    filt_rd_d     = 1'b0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    frame_done_d  = 1'b0;
    err_ovr_d     = err_ovr_q;
    err_to_d      = err_to_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d       = S_LOAD;
          in_cnt_d      = '0;
          out_cnt_d     = '0;
          drain_cnt_d   = '0;
          to_cnt_d      = '0;
          outstanding_d = 1'b0;
          err_ovr_d     = 1'b0;
          err_to_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (i_rx_valid) begin
          conv_drdy_d = 1'b1;
          conv_data_d = i_rx_data;
          in_cnt_d    = in_cnt_q + IN_W'(1);
          if (in_cnt_q == IN_LAST) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (i_rx_valid) err_ovr_d = 1'b1;
        drain_cnt_d = drain_cnt_q + DR_W'(1);
        if (drain_cnt_q == DR_LAST) state_d = S_SEND;
      end
      S_SEND: begin
        if (i_rx_valid) err_ovr_d = 1'b1;
        // A response landing in the expiry cycle is still accepted.
        if (outstanding_q) begin
          if (i_filt_valid) begin
            tx_start_d    = 1'b1;
            tx_data_d     = i_filt_data;
            out_cnt_d     = out_cnt_q + OUT_W'(1);
            outstanding_d = 1'b0;
            if (out_cnt_q == OUT_LAST) state_d = S_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            err_to_d      = 1'b1;
            outstanding_d = 1'b0;
            state_d       = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      S_DONE: begin
        if (i_rx_valid) err_ovr_d = 1'b1;
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      filt_rd_d     = 1'b1;
      outstanding_d = 1'b1;
      to_cnt_d      = '0;
    end
  end

  assign o_conv_drdy   = conv_drdy_q;
  assign o_conv_data   = conv_data_q;
  assign o_filt_rd     = filt_rd_q;
  assign o_tx_start    = tx_start_q;
  assign o_tx_data     = tx_data_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_frame_done  = frame_done_q;
  assign o_err_overrun = err_ovr_q;
  assign o_err_timeout = err_to_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus pushes expected bytes/cycles, a negedge monitor pops and compares.
module tb_frame_sequencer;
  localparam int ROWS = 4, COLS = 5, NPIX = 20, OUTP = 6, DRC = 4, TOUT = 16;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic       filt_valid = 1'b0, tx_idle = 1'b0;
  logic [7:0] rx_data = 8'h00, filt_data = 8'h00;
  logic       conv_drdy, filt_rd, tx_start, busy, frame_done, err_ovr, err_to;
  logic [7:0] conv_data, tx_data;

  frame_sequencer #(
    .row_depth(ROWS), .column_depth(COLS), .D_BITS(8), .OUT_PIXELS(OUTP),
    .DRAIN_CYC(DRC), .RD_TIMEOUT(TOUT)
  ) dut (
    .i_clk(clk), .reset(reset), .i_start(start), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_conv_drdy(conv_drdy), .o_conv_data(conv_data), .o_filt_rd(filt_rd),
    .i_filt_valid(filt_valid), .i_filt_data(filt_data), .i_tx_idle(tx_idle),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_frame_done(frame_done),
    .o_err_overrun(err_ovr), .o_err_timeout(err_to)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: frame phase (0 idle, 1 loading, 2 loaded/reading out) plus scoreboard queues.
  int         phase = 0, loaded = 0, tx_seen = 0, done_cnt = 0, drain_cyc = 0;
  int         exp_done_cyc = -1, last_tx = -100;
  bit         ovr_m = 0;
  logic [7:0] conv_q[$];
  int         conv_t[$];
  logic [7:0] tx_q[$];
  int         tx_t[$];
  int         rd_cyc[$];

  bit idle_d1 = 0, prev_rd = 0, prev_tx = 0, prev_done = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (conv_drdy) begin
        if (conv_q.size() == 0) check("conv_unexpected", 1, 0);
        else begin
          check("conv_data", conv_data, conv_q.pop_front());
          check("conv_latency", cyc, conv_t.pop_front());
        end
      end
      if (filt_rd) begin
        check("rd_only_after_full_load", phase, 2);
        check("rd_needs_tx_idle", idle_d1, 1);
        check("rd_gap_after_tx", (cyc - last_tx) >= 2, 1);
        rd_cyc.push_back(cyc);
      end
      if (tx_start) begin
        if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
        else begin
          check("tx_data", tx_data, tx_q.pop_front());
          check("tx_latency", cyc, tx_t.pop_front());
        end
        last_tx = cyc;
        tx_seen++;
        if (tx_seen == OUTP) exp_done_cyc = cyc + 1;
      end
      if (frame_done) begin
        check("frame_done_time", cyc, exp_done_cyc);
        exp_done_cyc = -1;
        done_cnt++;
        phase = 0;
      end
      if (filt_rd || tx_start || frame_done)
        check("strobe_width", (filt_rd && prev_rd) || (tx_start && prev_tx) ||
              (frame_done && prev_done), 0);
    end
    idle_d1 = tx_idle; prev_rd = filt_rd; prev_tx = tx_start; prev_done = frame_done;
  end

  // Filter output memory model: answers each request after resp_min..resp_max cycles.
  int resp_min = 2, resp_max = 2, drop_idx = -1, req_idx = 0, resp_d = 0;
  bit rand_data = 0, stray_en = 0, idle_rand = 0;
  initial forever begin
    @(negedge clk);
    if (reset && filt_rd) begin
      if (req_idx == drop_idx) req_idx++;
      else begin
        resp_d = $urandom_range(resp_max, resp_min);
        repeat (resp_d) @(posedge clk);
        #1;
        filt_valid = 1'b1;
        filt_data  = rand_data ? 8'($urandom) : 8'hA0 + 8'(req_idx);
        tx_q.push_back(filt_data);
        tx_t.push_back(cyc + 1);
        req_idx++;
        @(posedge clk); #1;
        if (stray_en && $urandom_range(1, 0) == 1) begin
          filt_data = ~filt_data;
          @(posedge clk); #1;
        end
        filt_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (idle_rand) tx_idle = ($urandom_range(3, 0) != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    phase = 1; loaded = 0; tx_seen = 0; req_idx = 0; ovr_m = 0;
    rd_cyc.delete();
    tick();
    start = 1'b0;
    check("start_clears_overrun", err_ovr, 0);
    check("start_clears_timeout", err_to, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    if (phase == 1) begin
      conv_q.push_back(b);
      conv_t.push_back(cyc + 1);
      loaded++;
      if (loaded == NPIX) begin phase = 2; drain_cyc = cyc + 1; end
    end else if (phase == 2) ovr_m = 1;
    tick();
    rx_valid = 1'b0;
    check("overrun_flag", err_ovr, ovr_m);
    tick(gap);
  endtask

  task automatic wait_done(input int exp_cnt);
    int t0;
    t0 = cyc;
    while (done_cnt < exp_cnt && cyc - t0 < 2000) tick();
    check("frame_done_seen", done_cnt, exp_cnt);
    check("busy_after_done", busy, 0);
    check("tx_count", tx_seen, OUTP);
    check("timeout_clear", err_to, 0);
  endtask

  task automatic check_quiet(input string name);
    check(name, {conv_drdy, conv_data, filt_rd, tx_start, tx_data, busy, frame_done,
                 err_ovr, err_to}, 0);
  endtask

  initial begin
    int t0, k;
    // 1: reset and idle behaviour
    tx_idle = 1'b1;
    tick(3);
    check_quiet("reset_held");
    reset = 1'b1;
    tick();
    check_quiet("after_reset");
    for (int i = 0; i < 3; i++) send_byte(8'h55, 1);
    check("idle_rx_not_busy", busy, 0);

    // 2 + 3: load 20 bytes, overrun byte, fixed-latency readout
    do_start();
    check("busy_in_load", busy, 1);
    for (int i = 0; i < NPIX; i++) send_byte(8'(i), 2);
    send_byte(8'hEE, 2);
    wait_done(1);
    check("first_rd_after_drain", rd_cyc[0], drain_cyc + DRC);

    // 4: TX back-pressure
    do_start();
    for (int i = 0; i < NPIX; i++) send_byte(8'(i + 32), 0);
    t0 = cyc;
    while (tx_seen < 2 && cyc - t0 < 500) tick();
    check("bp_two_tx_seen", tx_seen, 2);
    tx_idle = 1'b0;
    tick(30);
    check("bp_no_rd_in_window", rd_cyc.size(), 2);
    tx_idle = 1'b1;
    k = cyc;
    t0 = cyc;
    while (rd_cyc.size() < 3 && cyc - t0 < 100) tick();
    check("bp_rd_seen", rd_cyc.size(), 3);
    if (rd_cyc.size() >= 3) check("bp_rd_latency", rd_cyc[2], k + 1);
    wait_done(2);

    // 5: timeout on the third request
    drop_idx = 2;
    do_start();
    for (int i = 0; i < NPIX; i++) send_byte(8'($urandom), 1);
    send_byte(8'h77, 0);
    t0 = cyc;
    while (!err_to && cyc - t0 < 500) tick();
    check("timeout_set", err_to, 1);
    if (rd_cyc.size() >= 3) check("timeout_latency", cyc, rd_cyc[2] + TOUT);
    else check("timeout_rd_count", rd_cyc.size(), 3);
    check("timeout_idle", busy, 0);
    phase = 0;
    tick(10);
    check("timeout_no_done", done_cnt, 2);
    check("timeout_tx_count", tx_seen, 2);
    drop_idx = -1;

    // 6: reset mid-LOAD, then a randomized frame
    do_start();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1);
    reset = 1'b0;
    tick(2);
    conv_q.delete(); conv_t.delete(); phase = 0;
    reset = 1'b1;
    tick();
    check_quiet("mid_load_reset");
    rand_data = 1; stray_en = 1; resp_min = 1; resp_max = 6; idle_rand = 1;
    do_start();
    for (int i = 0; i < NPIX; i++) send_byte(8'($urandom), $urandom_range(3, 0));
    wait_done(3);

    // back-to-back random frame
    do_start();
    for (int i = 0; i < NPIX; i++) send_byte(8'($urandom), 0);
    wait_done(4);
    idle_rand = 0;
    tick(5);
    check("conv_queue_empty", conv_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
